// File: rtl/ac_scan_ctrl.sv
// AC coefficient scan controller: walks positions k=1..63 across blocks b=0..n-1
// and turns the coefficient stream into (run, level) pairs for the AC VLC stage.
module ac_scan_ctrl #(
  parameter int unsigned MAX_BLOCK_NUM = 8,
  parameter int unsigned COEF_W        = 32,
  parameter int unsigned ADDR_W        = 9,
  parameter int unsigned RUN_W         = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       block_num,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [COEF_W-1:0] rd_data,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [RUN_W-1:0]  pair_run,
  output logic [COEF_W-1:0] pair_level
);

  localparam int unsigned BLK_W = (MAX_BLOCK_NUM > 1) ? $clog2(MAX_BLOCK_NUM) : 1;
  localparam int unsigned N_W   = BLK_W + 1;
  localparam int unsigned K_W   = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [N_W-1:0]   n;
  logic [BLK_W-1:0] b;
  logic [K_W-1:0]   k;
  logic [RUN_W-1:0] run;

  logic [N_W-1:0]   n_clamped;
  logic             last_blk;
  logic             scan_end;
  logic [BLK_W-1:0] b_adv;
  logic [K_W-1:0]   k_adv;
  logic             coef_zero;

  // Next-position arithmetic shared by the zero path in EVAL and the handshake in EMIT
  always_comb begin
    n_clamped = N_W'(block_num);
    if (block_num > 32'(MAX_BLOCK_NUM)) begin
      n_clamped = N_W'(MAX_BLOCK_NUM);
    end
    last_blk  = (N_W'(b) == (n - N_W'(1)));
    scan_end  = last_blk && (k == K_W'(63));
    b_adv     = last_blk ? '0 : (b + BLK_W'(1));
    k_adv     = last_blk ? (k + K_W'(1)) : k;
    coef_zero = (rd_data == '0);
  end

  // Single-process FSM; every output is a register updated on the transition into its state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      n          <= '0;
      b          <= '0;
      k          <= '0;
      run        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      pair_valid <= 1'b0;
      pair_run   <= '0;
      pair_level <= '0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n    <= n_clamped;
            k    <= K_W'(1);
            b    <= '0;
            run  <= '0;
            busy <= 1'b1;
            if (n_clamped == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_FETCH;
              rd_en   <= 1'b1;
              rd_addr <= ADDR_W'(1);
            end
          end
        end

        S_FETCH: begin
          state <= S_EVAL;
        end

        S_EVAL: begin
          if (coef_zero) begin
            run <= run + RUN_W'(1);
            if (scan_end) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              b       <= b_adv;
              k       <= k_adv;
              state   <= S_FETCH;
              rd_en   <= 1'b1;
              rd_addr <= ADDR_W'({b_adv, k_adv});
            end
          end else begin
            pair_run   <= run;
            pair_level <= rd_data;
            pair_valid <= 1'b1;
            state      <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (pair_ready) begin
            pair_valid <= 1'b0;
            run        <= '0;
            if (scan_end) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              b       <= b_adv;
              k       <= k_adv;
              state   <= S_FETCH;
              rd_en   <= 1'b1;
              rd_addr <= ADDR_W'({b_adv, k_adv});
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac_scan_ctrl.sv
// Self-checking bench for ac_scan_ctrl: table of slice scans plus backpressure,
// ignored-start and mid-EMIT reset sequences against a registered-read memory.
module tb_ac_scan_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] block_num;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic        pair_valid;
  logic        pair_ready;
  logic [8:0]  pair_run;
  logic [31:0] pair_level;

  ac_scan_ctrl #(
    .MAX_BLOCK_NUM(8),
    .COEF_W(32),
    .ADDR_W(9),
    .RUN_W(9)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .block_num(block_num),
    .busy(busy),
    .done(done),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .pair_valid(pair_valid),
    .pair_ready(pair_ready),
    .pair_run(pair_run),
    .pair_level(pair_level)
  );

  typedef struct {
    int bn;
    int a0; int v0;
    int a1; int v1;
    int np;
    int r0; int l0;
    int r1; int l1;
    int cyc;
    int reads;
  } vec_t;

  logic [31:0] mem [0:511];
  int checks;
  int failures;
  int viol;
  int busy_cnt;
  bit mon_en;
  int rd_q[$];
  int run_q[$];
  int lvl_q[$];

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Mid-cycle monitor: collects reads, accepted pairs and protocol violations
  always @(negedge clock) begin
    if (rd_en && pair_valid) viol++;
    if (done && pair_valid) viol++;
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (pair_valid && pair_ready) begin
        run_q.push_back(int'(pair_run));
        lvl_q.push_back($signed(pair_level));
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = '0;
  endtask

  // Runs one slice scan; optional glitch cycle pulses start again while busy
  task automatic do_vec(input vec_t v, input int glitch, input bit load_mem);
    int cyc;
    int nn;
    int idx;
    int err;
    if (load_mem) begin
      clear_mem();
      if (v.a0 >= 0) mem[v.a0] = v.v0;
      if (v.a1 >= 0) mem[v.a1] = v.v1;
    end
    pair_ready = 1'b1;
    rd_q.delete();
    run_q.delete();
    lvl_q.delete();
    busy_cnt = 0;
    block_num = v.bn;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    mon_en = 1'b1;
    cyc = 1;
    while (!done && cyc < 3000) begin
      if (glitch != 0 && cyc == glitch) begin
        start = 1'b1;
        block_num = 2;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      cyc++;
    end
    chk("done_seen", int'(done), 1);
    chk("done_cycle", cyc, v.cyc);
    @(posedge clock);
    #1;
    mon_en = 1'b0;
    chk("busy_after_done", int'(busy), 0);
    chk("done_width", int'(done), 0);
    chk("busy_cycles", busy_cnt, v.cyc);
    chk("read_count", rd_q.size(), v.reads);
    nn = (v.bn > 8) ? 8 : v.bn;
    idx = 0;
    err = 0;
    for (int kk = 1; kk < 64; kk++) begin
      for (int bb = 0; bb < nn; bb++) begin
        if (idx < rd_q.size() && rd_q[idx] != bb * 64 + kk) err++;
        idx++;
      end
    end
    chk("read_order", err, 0);
    chk("pair_count", run_q.size(), v.np);
    if (v.np >= 1 && run_q.size() >= 1) begin
      chk("pair0_run", run_q[0], v.r0);
      chk("pair0_level", lvl_q[0], v.l0);
    end
    if (v.np >= 2 && run_q.size() >= 2) begin
      chk("pair1_run", run_q[1], v.r1);
      chk("pair1_level", lvl_q[1], v.l1);
    end
    block_num = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_pair_valid"}, int'(pair_valid), 0);
    chk({tag, "_pair_run"}, int'(pair_run), 0);
    chk({tag, "_pair_level"}, int'(pair_level), 0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    int cyc;

    vecs[0] = '{1,   0,  99,  -1,     0, 0,   0,     0,  0,  0,  127,  63};
    vecs[1] = '{1,   1,   5,  63,    -3, 2,   0,     5, 61, -3,  129,  63};
    vecs[2] = '{2,  65,   7,   2,    -1, 2,   1,     7,  0, -1,  255, 126};
    vecs[3] = '{0,   1,   4,  -1,     0, 0,   0,     0,  0,  0,    1,   0};
    vecs[4] = '{12, 511,  4,  -1,     0, 1, 503,     4,  0,  0, 1010, 504};
    vecs[5] = '{1,  64,   8,   2, -2048, 1,   1, -2048,  0,  0,  128,  63};

    checks = 0;
    failures = 0;
    viol = 0;
    busy_cnt = 0;
    mon_en = 1'b0;
    clock = 1'b0;
    reset_n = 1'b0;
    start = 1'b0;
    block_num = '0;
    pair_ready = 1'b1;
    clear_mem();

    #12;
    chk_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_vec(vecs[i], 0, 1'b1);
      repeat (2) @(posedge clock);
      #1;
    end

    // Start pulse while busy must not disturb a single-block scan
    v = vecs[0];
    do_vec(v, 10, 1'b1);
    repeat (2) @(posedge clock);
    #1;

    // Backpressure: hold pair_ready low for 5 cycles during EMIT
    clear_mem();
    mem[1] = 9;
    pair_ready = 1'b0;
    block_num = 1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!pair_valid && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("bp_valid_cycle", cyc, 3);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) pair_ready = 1'b1;
      chk("bp_valid_held", int'(pair_valid), 1);
      chk("bp_run_held", int'(pair_run), 0);
      chk("bp_level_held", $signed(pair_level), 9);
      chk("bp_no_rd_en", int'(rd_en), 0);
      @(posedge clock);
      #1;
    end
    chk("bp_valid_drop", int'(pair_valid), 0);
    chk("bp_next_fetch", int'(rd_en), 1);
    chk("bp_next_addr", int'(rd_addr), 2);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("bp_done_seen", int'(done), 1);
    block_num = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset in EMIT drops the pair; the rescan must start fresh
    clear_mem();
    mem[1] = 5;
    pair_ready = 1'b0;
    block_num = 1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!pair_valid && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("rst_emit_reached", int'(pair_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_no_done", int'(done), 0);
    mem[1] = 0;
    mem[2] = 6;
    v = '{1, -1, 0, -1, 0, 1, 1, 6, 0, 0, 128, 63};
    do_vec(v, 0, 1'b0);

    chk("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
